serial_set_compare: RTL and testbench

- Multi-cycle compare unit for the set-class instructions SEQ, SLT, SLE and SCO of the 16-bit datapath.
- Processes operands one digit per cycle, LSB-first, through a single narrow adder.
- Sits beside the ALU and hands a 1-bit result to writeback, zero-extended by the caller.
- Built with a start/busy/done handshake so the pipeline can stall on it.

---
 rtl/serial_set_compare_pkg.sv | 34 +++
 rtl/serial_set_compare_digit_adder.sv | 22 ++
 rtl/serial_set_compare.sv | 146 ++++++++++++++
 tb/tb_serial_set_compare.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/serial_set_compare_pkg.sv
// Shared ALU package: set-class op encodings, compare FSM states and digit sizing.
// Also holds the rule that turns the final flags into the 1-bit set result.
package serial_set_compare_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int DIGIT_DEF = 4;
  localparam int NDIGITS   = WIDTH_DEF / DIGIT_DEF;

  localparam logic [1:0] SET_SEQ = 2'b00;
  localparam logic [1:0] SET_SLT = 2'b01;
  localparam logic [1:0] SET_SLE = 2'b10;
  localparam logic [1:0] SET_SCO = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } set_state_t;

  // Signed less-than comes from N^V of A-B, equality from the all-zero sum.
  function automatic logic set_result(input logic [1:0] op, input logic n,
                                      input logic v, input logic c, input logic eq);
    logic res;
    case (op)
      SET_SEQ: res = eq;
      SET_SLT: res = n ^ v;
      SET_SLE: res = (n ^ v) | eq;
      SET_SCO: res = c;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/serial_set_compare_digit_adder.sv
// DIGIT-bit adder slice used once per cycle by the serial compare unit.
// Also reports the carry into the MSB so the caller can form signed overflow.
module digit_adder #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] i_a,
  input  logic [DIGIT-1:0] i_b,
  input  logic             i_cin,
  output logic [DIGIT-1:0] o_sum,
  output logic             o_cout,
  output logic             o_cmsb
);

  logic [DIGIT:0] w_full;

  assign w_full = {1'b0, i_a} + {1'b0, i_b} + {{DIGIT{1'b0}}, i_cin};
  assign o_sum  = w_full[DIGIT-1:0];
  assign o_cout = w_full[DIGIT];
  // The MSB sum bit is a^b^cin, so the carry into it falls out by XOR.
  assign o_cmsb = w_full[DIGIT-1] ^ i_a[DIGIT-1] ^ i_b[DIGIT-1];

endmodule

// File: rtl/serial_set_compare.sv
// Multi-cycle SEQ/SLT/SLE/SCO unit: one digit per cycle, LSB-first, through a
// single narrow adder, with a start/busy/done handshake for pipeline stalls.
module serial_set_compare
  import serial_set_compare_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DIGIT = DIGIT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] InA,
  input  logic [WIDTH-1:0] InB,
  output logic             busy,
  output logic             done,
  output logic             Out
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = $clog2(NDIG + 1);
  localparam logic [CW-1:0] LAST_DIG  = CW'(NDIG - 1);
  localparam logic [CW-1:0] FINAL_CNT = CW'(NDIG);

  generate
    if ((WIDTH % DIGIT) != 0 || DIGIT < 1) begin : g_bad_width
      $error("serial_set_compare: WIDTH must be a multiple of DIGIT");
    end
  endgenerate

  set_state_t       r_state;
  set_state_t       w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [1:0]       r_op;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic             r_zero;
  logic             r_n;
  logic             r_v;
  logic             r_busy;
  logic             r_done;
  logic             r_out;

  logic [DIGIT-1:0] w_sum;
  logic             w_cout;
  logic             w_cmsb;
  logic             w_last;
  logic             w_sum_zero;

  digit_adder #(.DIGIT(DIGIT)) u_digit_adder (
    .i_a    (r_a[DIGIT-1:0]),
    .i_b    (r_b[DIGIT-1:0]),
    .i_cin  (r_carry),
    .o_sum  (w_sum),
    .o_cout (w_cout),
    .o_cmsb (w_cmsb)
  );

  assign w_last     = (r_cnt == LAST_DIG);
  assign w_sum_zero = (w_sum == {DIGIT{1'b0}});

  // Next-state selection for the IDLE/RUN/DONE sequence.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (r_cnt == FINAL_CNT) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State, handshake outputs, operand shifting and flag accumulation.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_a     <= {WIDTH{1'b0}};
      r_b     <= {WIDTH{1'b0}};
      r_op    <= 2'b00;
      r_cnt   <= {CW{1'b0}};
      r_carry <= 1'b0;
      r_zero  <= 1'b0;
      r_n     <= 1'b0;
      r_v     <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_out   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != ST_IDLE);
      r_done  <= (w_state_nxt == ST_DONE);
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_a     <= InA;
            // Subtract ops feed ~B with carry-in 1 so the adder forms A-B.
            r_b     <= (op == SET_SCO) ? InB : ~InB;
            r_op    <= op;
            r_carry <= (op != SET_SCO);
            r_cnt   <= {CW{1'b0}};
            r_zero  <= 1'b1;
          end
        end
        ST_RUN: begin
          if (r_cnt != FINAL_CNT) begin
            r_a     <= r_a >> DIGIT;
            r_b     <= r_b >> DIGIT;
            r_carry <= w_cout;
            r_zero  <= r_zero & w_sum_zero;
            r_cnt   <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
            if (w_last) begin
              r_n <= w_sum[DIGIT-1];
              r_v <= w_cmsb ^ w_cout;
            end
          end else begin
            r_out <= set_result(r_op, r_n, r_v, r_carry, r_zero);
          end
        end
        ST_DONE: begin
          r_cnt <= r_cnt;
        end
        default: begin
          r_cnt <= {CW{1'b0}};
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign Out  = r_out;

endmodule

// File: tb/tb_serial_set_compare.sv
// Randomized and directed bench for serial_set_compare against a word-level
// model built from signed comparison and a full-width carry.
module tb_serial_set_compare;
  import serial_set_compare_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [15:0] InA;
  logic [15:0] InB;
  logic        busy;
  logic        done;
  logic        Out;

  int total = 0;
  int bad   = 0;
  localparam int EXP_LAT = NDIGITS + 1;

  serial_set_compare dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .InA(InA), .InB(InB),
    .busy(busy), .done(done), .Out(Out)
  );

  always #5 clk = ~clk;

  function automatic logic model(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    case (o)
      SET_SEQ: return a == b;
      SET_SLT: return $signed(a) < $signed(b);
      SET_SLE: return $signed(a) <= $signed(b);
      default: return s[16];
    endcase
  endfunction

  // Issue one op; lat=-1 on timeout. Leaves the DUT back in IDLE.
  task automatic run_op(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                        output logic res, output int lat, output logic busy_acc);
    @(negedge clk);
    op = o; InA = a; InB = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    busy_acc = busy;
    lat = -1;
    res = 1'bx;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = i;
        res = Out;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; op = 2'b00; InA = 16'h0000; InB = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++; if (Out !== 1'b0) begin bad++; $display("FAIL reset_out got=%b exp=0", Out); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct { logic [1:0] o; logic [15:0] a; logic [15:0] b; logic e; } vec_t;

  task automatic test_directed();
    vec_t v[15];
    logic r; int lat; logic ba;
    v[0]  = '{SET_SLT, 16'h0001, 16'h0002, 1'b1};
    v[1]  = '{SET_SLT, 16'h0005, 16'h0003, 1'b0};
    v[2]  = '{SET_SEQ, 16'h000A, 16'h000A, 1'b1};
    v[3]  = '{SET_SLE, 16'h000A, 16'h000A, 1'b1};
    v[4]  = '{SET_SLT, 16'h000A, 16'h000A, 1'b0};
    v[5]  = '{SET_SEQ, 16'h0000, 16'h0000, 1'b1};
    v[6]  = '{SET_SLT, 16'hFFFE, 16'hFFFF, 1'b1};
    v[7]  = '{SET_SLT, 16'hFFFD, 16'hFFFC, 1'b0};
    v[8]  = '{SET_SLT, 16'h8000, 16'h7FFF, 1'b1};
    v[9]  = '{SET_SLT, 16'h7FFF, 16'h7FFE, 1'b0};
    v[10] = '{SET_SCO, 16'hFFFF, 16'h0001, 1'b1};
    v[11] = '{SET_SCO, 16'h7FFF, 16'h0001, 1'b0};
    v[12] = '{SET_SCO, 16'h8000, 16'h8000, 1'b1};
    v[13] = '{SET_SEQ, 16'h1234, 16'h1235, 1'b0};
    v[14] = '{SET_SLE, 16'h7FFF, 16'h8000, 1'b0};
    foreach (v[i]) begin
      run_op(v[i].o, v[i].a, v[i].b, r, lat, ba);
      total++; if (lat !== EXP_LAT) begin bad++; $display("FAIL dir_lat[%0d] got=%0d exp=%0d", i, lat, EXP_LAT); end
      total++; if (ba !== 1'b1) begin bad++; $display("FAIL dir_busy[%0d] got=%b exp=1", i, ba); end
      total++; if (r !== v[i].e) begin bad++; $display("FAIL dir_out[%0d] op=%0d a=%h b=%h got=%b exp=%b", i, v[i].o, v[i].a, v[i].b, r, v[i].e); end
    end
  endtask

  task automatic test_random();
    logic r; int lat; logic ba; logic [1:0] o; logic [15:0] a; logic [15:0] b;
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3));
      a = 16'($urandom);
      b = ($urandom_range(0, 3) == 0) ? a : 16'($urandom);
      run_op(o, a, b, r, lat, ba);
      total++; if (lat !== EXP_LAT) begin bad++; $display("FAIL rnd_lat[%0d] got=%0d exp=%0d", i, lat, EXP_LAT); end
      total++; if (r !== model(o, a, b)) begin bad++; $display("FAIL rnd_out[%0d] op=%0d a=%h b=%h got=%b exp=%b", i, o, a, b, r, model(o, a, b)); end
    end
  endtask

  task automatic test_busy_ignore();
    int pulses; logic res_seen; logic r; int lat; logic ba;
    run_op(SET_SCO, 16'h7FFF, 16'h0001, r, lat, ba);   // leaves Out=0
    @(negedge clk);
    op = SET_SLT; InA = 16'h0001; InB = 16'h0002; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; InA = 16'h0005; InB = 16'h0003; op = SET_SCO;
    @(negedge clk);
    op = SET_SEQ; InA = 16'h0042; InB = 16'h0042; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    total++; if (Out !== 1'b0) begin bad++; $display("FAIL hold_during_run got=%b exp=0", Out); end
    pulses = 0; res_seen = 1'bx;
    for (int i = 0; i < 14; i++) begin
      @(posedge clk); #1;
      if (done) begin pulses++; res_seen = Out; end
    end
    total++; if (pulses !== 1) begin bad++; $display("FAIL busy_ignore_pulses got=%0d exp=1", pulses); end
    total++; if (res_seen !== 1'b1) begin bad++; $display("FAIL busy_ignore_out got=%b exp=1", res_seen); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL busy_ignore_idle got=%b exp=0", busy); end
    total++; if (Out !== 1'b1) begin bad++; $display("FAIL out_hold_idle got=%b exp=1", Out); end
  endtask

  task automatic test_reset_abort();
    int pulses; logic r; int lat; logic ba;
    run_op(SET_SCO, 16'hFFFF, 16'h0001, r, lat, ba);   // leaves Out=1
    @(negedge clk);
    op = SET_SLT; InA = 16'h0005; InB = 16'h0003; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL abort_done got=%b exp=0", done); end
    total++; if (Out !== 1'b0) begin bad++; $display("FAIL abort_out got=%b exp=0", Out); end
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    total++; if (pulses !== 0) begin bad++; $display("FAIL abort_no_done got=%0d exp=0", pulses); end
    run_op(SET_SLT, 16'h0001, 16'h0002, r, lat, ba);
    total++; if (lat !== EXP_LAT) begin bad++; $display("FAIL after_abort_lat got=%0d exp=%0d", lat, EXP_LAT); end
    total++; if (r !== 1'b1) begin bad++; $display("FAIL after_abort_out got=%b exp=1", r); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_busy_ignore();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
